vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_timing_gen_if.sv | 18 +
 rtl/vga_timing_gen_pix_clk_en.sv | 30 +++
 rtl/vga_timing_gen.sv | 71 +++++++
 tb/tb_vga_timing_gen.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and counter types, also
// meant for downstream pixel generators that must agree on the raster.
package vga_pkg;

  localparam int unsigned VGA_CLK_DIV   = 4;
  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FP      = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BP      = 48;
  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FP      = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BP      = 33;

  localparam int unsigned VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  // True when lo <= v < hi, evaluated in 32-bit unsigned so hi may reach 1024.
  function automatic logic in_span(input cnt_t v, input int unsigned lo, input int unsigned hi);
    int unsigned vi;
    vi = 32'(v);
    return (vi >= lo) && (vi < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle driven by vga_timing_gen.
// pix_en is the only strobe: a pixel is presented on every clk where pix_en=1;
// there is no ready/backpressure, consumers must accept every strobe.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic HS;
  logic VS;
  cnt_t x;
  cnt_t y;
  logic blank;
  logic pix_en;
  logic line_end;
  logic frame_end;

  modport master (output HS, VS, x, y, blank, pix_en, line_end, frame_end);
  modport slave  (input  HS, VS, x, y, blank, pix_en, line_end, frame_end);
endinterface

// File: rtl/vga_timing_gen_pix_clk_en.sv
// Pixel-rate enable: divides clk by CLK_DIV into a one-clk strobe.
module pix_clk_en #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic en
);
  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("pix_clk_en: CLK_DIV must be at least 1");
  end

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Gated by reset so CLK_DIV=1 still reports no strobe while held in reset.
  assign en = (cnt_q == LAST) && !reset;
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters with zero-latency sync/blank decode.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV   = VGA_CLK_DIV,
  parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned H_FP      = VGA_H_FP,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BP      = VGA_H_BP,
  parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
  parameter int unsigned V_FP      = VGA_V_FP,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BP      = VGA_V_BP
) (
  input  logic              clk,
  input  logic              reset,
  vga_timing_gen_if.master  vga
);
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL == 0 || V_TOTAL == 0) begin : g_bad_totals
    $error("vga_timing_gen: line/frame totals must be 1..1024 for 10-bit counters");
  end

  localparam cnt_t X_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t Y_LAST = cnt_t'(V_TOTAL - 1);

  logic pix_en;
  cnt_t x_q, x_d;
  cnt_t y_q, y_d;

  pix_clk_en #(.CLK_DIV(CLK_DIV)) u_pix_clk_en (
    .clk   (clk),
    .reset (reset),
    .en    (pix_en)
  );

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (pix_en) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + cnt_t'(1);
      end else begin
        x_d = x_q + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // Decoded straight from the counter registers so they move on the same edge as x/y.
  assign vga.x         = x_q;
  assign vga.y         = y_q;
  assign vga.pix_en    = pix_en;
  assign vga.HS        = !in_span(x_q, H_VISIBLE + H_FP, H_VISIBLE + H_FP + H_SYNC);
  assign vga.VS        = !in_span(y_q, V_VISIBLE + V_FP, V_VISIBLE + V_FP + V_SYNC);
  assign vga.blank     = (32'(x_q) >= H_VISIBLE) || (32'(y_q) >= V_VISIBLE);
  assign vga.line_end  = pix_en && (x_q == X_LAST);
  assign vga.frame_end = vga.line_end && (y_q == Y_LAST);
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default build (line level), a reduced
// raster build (frame level, mid-frame reset) and a CLK_DIV=1 reduced build.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int REC_W = 25;

  // Reduced raster: H 16+2+4+3=25 (HS low x=18..21), V 8+2+2+3=15 (VS low y=10..11).
  localparam int S_HV = 16, S_HFP = 2, S_HS = 4, S_HBP = 3;
  localparam int S_VV = 8,  S_VFP = 2, S_VS = 2, S_VBP = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d = 1'b1;
  logic rst_s = 1'b1;
  logic rst_o = 1'b1;

  vga_timing_gen_if d_if ();
  vga_timing_gen_if s_if ();
  vga_timing_gen_if o_if ();

  vga_timing_gen u_def (
    .clk   (clk),
    .reset (rst_d),
    .vga   (d_if)
  );

  vga_timing_gen #(
    .CLK_DIV(4), .H_VISIBLE(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_VISIBLE(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
  ) u_small (
    .clk   (clk),
    .reset (rst_s),
    .vga   (s_if)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_VISIBLE(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_VISIBLE(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
  ) u_div1 (
    .clk   (clk),
    .reset (rst_o),
    .vga   (o_if)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [REC_W-1:0] exp_d[$];
  logic [REC_W-1:0] exp_s[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [REC_W-1:0] pack(input logic [9:0] x, input logic [9:0] y,
                                             input logic hs, input logic vs, input logic bl,
                                             input logic le, input logic fe);
    return {x, y, hs, vs, bl, le, fe};
  endfunction

  // Expected pixel record from hand-derived sync windows (inclusive bounds).
  function automatic logic [REC_W-1:0] exp_rec(input int x, input int y, input int h_vis,
                                                input int hs_lo, input int hs_hi, input int h_tot,
                                                input int v_vis, input int vs_lo, input int vs_hi,
                                                input int v_tot);
    logic hs, vs, bl, le, fe;
    hs = !(x >= hs_lo && x <= hs_hi);
    vs = !(y >= vs_lo && y <= vs_hi);
    bl = (x >= h_vis) || (y >= v_vis);
    le = (x == h_tot - 1);
    fe = le && (y == v_tot - 1);
    return {10'(x), 10'(y), hs, vs, bl, le, fe};
  endfunction

  // Monitors: one record per pixel strobe.
  always @(negedge clk) begin
    if (d_if.pix_en && exp_d.size() > 0)
      check("def_pix", pack(d_if.x, d_if.y, d_if.HS, d_if.VS, d_if.blank, d_if.line_end,
                            d_if.frame_end), exp_d.pop_front());
  end

  always @(negedge clk) begin
    if (s_if.pix_en && exp_s.size() > 0)
      check("small_pix", pack(s_if.x, s_if.y, s_if.HS, s_if.VS, s_if.blank, s_if.line_end,
                              s_if.frame_end), exp_s.pop_front());
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  int n, found, last, strobes, bad_period, hs_low, bl_hi, le_hi, vs_low, bad_blank, pe_zero;
  int fe_first, fe_second, fe_cnt;

  initial begin
    // Default build: reset held 3 clks.
    repeat (3) @(posedge clk);
    #1;
    check("rst_x", d_if.x, 0);
    check("rst_y", d_if.y, 0);
    check("rst_hs", d_if.HS, 1);
    check("rst_vs", d_if.VS, 1);
    check("rst_blank", d_if.blank, 0);
    check("rst_pix_en", d_if.pix_en, 0);
    check("rst_line_end", d_if.line_end, 0);
    check("rst_frame_end", d_if.frame_end, 0);

    for (int p = 0; p < 1600; p++)
      exp_d.push_back(exp_rec(p % 800, p / 800, 640, 656, 751, 800, 480, 490, 491, 525));
    rst_d = 1'b0;

    n = 0; found = 0;
    repeat (20) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (d_if.pix_en) begin found = 1; break; end
    end
    check("def_first_pix_en_clks", n, 3);

    // Two lines from the first strobe: 6400 clks.
    strobes = 0; bad_period = 0; last = 0; hs_low = 0; bl_hi = 0; le_hi = 0;
    for (int i = 0; i < 6400; i++) begin
      if (i > 0) @(negedge clk);
      if (!d_if.HS) hs_low++;
      if (d_if.blank) bl_hi++;
      if (d_if.line_end) le_hi++;
      if (d_if.pix_en) begin
        strobes++;
        if (i > 0 && i - last != 4) bad_period++;
        last = i;
      end
    end
    check("def_strobes", strobes, 1600);
    check("def_pix_period_errs", bad_period, 0);
    check("def_hs_low_clks", hs_low, 768);
    check("def_blank_clks", bl_hi, 1280);
    check("def_line_end_clks", le_hi, 2);
    check("def_x_after_2_lines", d_if.x, 0);
    check("def_y_after_2_lines", d_if.y, 2);
    check("def_queue_left", exp_d.size(), 0);

    // Reduced raster: one frame plus the wrap pixel through the scoreboard.
    for (int p = 0; p < 376; p++)
      exp_s.push_back(exp_rec(p % 25, (p / 25) % 15, S_HV, 18, 21, 25, S_VV, 10, 11, 15));
    @(posedge clk); #1;
    rst_s = 1'b0;

    found = 0;
    repeat (2000) begin
      @(negedge clk);
      if (s_if.frame_end) begin found = 1; break; end
    end
    check("small_first_frame_end_seen", found, 1);

    n = 0; found = 0; vs_low = 0; bad_blank = 0; bl_hi = 0;
    repeat (3000) begin
      @(negedge clk); n++;
      if (!s_if.VS) vs_low++;
      if (s_if.blank) bl_hi++;
      if (s_if.y >= 10'(S_VV) && !s_if.blank) bad_blank++;
      if (s_if.frame_end) begin found = 1; break; end
    end
    check("small_frame_period_clks", n, 1500);
    check("small_vs_low_clks", vs_low, 200);
    check("small_blank_clks", bl_hi, 988);
    check("small_unblanked_in_vblank", bad_blank, 0);
    check("small_queue_left", exp_s.size(), 0);

    // Mid-frame reset at x=20, y=10, divider=2.
    found = 0;
    repeat (3000) begin
      @(negedge clk);
      if (s_if.pix_en && s_if.x == 10'd19 && s_if.y == 10'd10) begin found = 1; break; end
    end
    check("small_mid_point_seen", found, 1);
    repeat (3) @(posedge clk);
    #1;
    check("mid_pre_x", s_if.x, 20);
    check("mid_pre_y", s_if.y, 10);
    check("mid_pre_hs", s_if.HS, 0);
    check("mid_pre_vs", s_if.VS, 0);
    rst_s = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_x", s_if.x, 0);
    check("mid_rst_y", s_if.y, 0);
    check("mid_rst_hs", s_if.HS, 1);
    check("mid_rst_vs", s_if.VS, 1);
    check("mid_rst_pix_en", s_if.pix_en, 0);
    rst_s = 1'b0;
    n = 0;
    repeat (20) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (s_if.pix_en) break;
    end
    check("mid_first_pix_en_clks", n, 3);

    // CLK_DIV=1 build.
    @(posedge clk); #1;
    rst_o = 1'b0;
    pe_zero = 0; fe_cnt = 0; fe_first = -1; fe_second = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i == 0) check("div1_first_pix_en", o_if.pix_en, 1);
      if (!o_if.pix_en) pe_zero++;
      if (o_if.frame_end) begin
        fe_cnt++;
        if (fe_first < 0) fe_first = i;
        else if (fe_second < 0) fe_second = i;
      end
    end
    check("div1_pix_en_low_clks", pe_zero, 0);
    check("div1_frame_end_count", fe_cnt, 2);
    check("div1_first_frame_end_idx", fe_first, 374);
    check("div1_frame_period_clks", fe_second - fe_first, 375);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
